// File: rtl/gmii_ta_pkg.sv
// Shared constants, types and latency helper for the GMII traffic analyzer.
// No logic or state of its own; no latency or backpressure.
package gmii_ta_pkg;

  localparam logic [7:0]  GMII_PREAMBLE   = 8'h55;
  localparam logic [7:0]  GMII_SFD        = 8'hD5;
  localparam logic [31:0] NSEC_PER_SEC    = 32'd1_000_000_000;
  localparam logic [31:0] LAT_SAT         = 32'hFFFF_FFFF;
  localparam logic [31:0] STAMP_WIN_BYTES = 32'd14;

  localparam logic [15:0] REG_PKTS_HI     = 16'h0000;
  localparam logic [15:0] REG_PKTS_LO     = 16'h0004;
  localparam logic [15:0] REG_OCTETS_HI   = 16'h0008;
  localparam logic [15:0] REG_OCTETS_LO   = 16'h000C;
  localparam logic [15:0] REG_IDLE_HI     = 16'h0010;
  localparam logic [15:0] REG_IDLE_LO     = 16'h0014;
  localparam logic [15:0] REG_TS_SEC_HI   = 16'h0018;
  localparam logic [15:0] REG_TS_SEC_LO   = 16'h001C;
  localparam logic [15:0] REG_TS_NSEC     = 16'h0020;
  localparam logic [15:0] REG_LAT_MIN     = 16'h0024;
  localparam logic [15:0] REG_LAT_MAX     = 16'h0028;
  localparam logic [15:0] REG_LAT_NSEC    = 16'h002C;
  localparam logic [15:0] REG_FRAME_SIZE  = 16'h0030;
  localparam logic [15:0] REG_FRAME_BUF   = 16'h0034;
  localparam logic [15:0] REG_CONTROL     = 16'h0038;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_PREAMBLE,
    RX_DATA
  } rx_state_t;

  typedef struct packed {
    logic [47:0] sec;
    logic [31:0] nsec;
  } ts_t;

  // One-way latency in ns; anything beyond one second apart, or negative, saturates.
  function automatic logic [31:0] calc_latency(input ts_t tx, input ts_t rx);
    logic [32:0] diff;
    logic [48:0] tx_sec_p1;
    calc_latency = LAT_SAT;
    diff         = '0;
    tx_sec_p1    = {1'b0, tx.sec} + 49'd1;
    if (rx.sec == tx.sec) begin
      diff = {1'b0, rx.nsec} - {1'b0, tx.nsec};
      if (!diff[32]) calc_latency = diff[31:0];
    end else if ({1'b0, rx.sec} == tx_sec_p1) begin
      diff = {1'b0, rx.nsec} + {1'b0, NSEC_PER_SEC} - {1'b0, tx.nsec};
      if (!diff[32]) calc_latency = diff[31:0];
    end
  endfunction

endpackage

// File: rtl/gmii_ta_regs.sv
// AXI4-Lite slave for the analyzer: 1-cycle ready pulse, response the cycle after, 64-bit hi/lo snapshots.
// Backpressure: one outstanding transaction per channel; BVALID/RVALID held until BREADY/RREADY.
module gmii_ta_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] C_BASEADDR         = 32'h2000_0000
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [63:0]                     pkts,
  input  logic [63:0]                     octets,
  input  logic [63:0]                     octets_idle,
  input  logic [47:0]                     ts_sec,
  input  logic [31:0]                     ts_nsec,
  input  logic [31:0]                     lat_min,
  input  logic [31:0]                     lat_max,
  input  logic [31:0]                     lat_nsec,
  input  logic [31:0]                     frame_size,
  input  logic [31:0]                     frame_buf_word,
  output logic                            ctrl_clear,
  output logic                            frame_size_rd,
  output logic                            frame_buf_rd
);
  import gmii_ta_pkg::*;

  logic        aw_ready_q, b_valid_q, ar_ready_q, r_valid_q;
  logic [31:0] r_data_q, rd_mux;
  logic [31:0] snap_pkts, snap_octets, snap_idle, snap_ts;
  logic [15:0] aw_off, ar_off;
  logic        aw_in_win, ar_in_win, aw_hs, ar_hs;
  logic        unused_wr;

  assign aw_off    = S_AXI_AWADDR[15:0];
  assign ar_off    = S_AXI_ARADDR[15:0];
  assign aw_in_win = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:16] == C_BASEADDR[C_S_AXI_ADDR_WIDTH-1:16];
  assign ar_in_win = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:16] == C_BASEADDR[C_S_AXI_ADDR_WIDTH-1:16];
  assign aw_hs     = S_AXI_AWVALID && S_AXI_WVALID && aw_ready_q;
  assign ar_hs     = S_AXI_ARVALID && ar_ready_q;

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = r_valid_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = r_data_q;

  assign ctrl_clear    = aw_hs && (aw_off == REG_CONTROL) && S_AXI_WDATA[0];
  assign frame_size_rd = ar_hs && (ar_off == REG_FRAME_SIZE);
  assign frame_buf_rd  = ar_hs && (ar_off == REG_FRAME_BUF);
  assign unused_wr     = ^{S_AXI_WSTRB, S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:1]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      aw_ready_q <= !aw_ready_q && !b_valid_q && S_AXI_AWVALID && S_AXI_WVALID && aw_in_win;
      if (aw_hs)             b_valid_q <= 1'b1;
      else if (S_AXI_BREADY) b_valid_q <= 1'b0;
    end
  end

  // Lo offsets return the low half captured by the preceding hi read.
  always_comb begin
    rd_mux = '0;
    case (ar_off)
      REG_PKTS_HI:    rd_mux = pkts[63:32];
      REG_PKTS_LO:    rd_mux = snap_pkts;
      REG_OCTETS_HI:  rd_mux = octets[63:32];
      REG_OCTETS_LO:  rd_mux = snap_octets;
      REG_IDLE_HI:    rd_mux = octets_idle[63:32];
      REG_IDLE_LO:    rd_mux = snap_idle;
      REG_TS_SEC_HI:  rd_mux = {16'h0000, ts_sec[47:32]};
      REG_TS_SEC_LO:  rd_mux = snap_ts;
      REG_TS_NSEC:    rd_mux = ts_nsec;
      REG_LAT_MIN:    rd_mux = lat_min;
      REG_LAT_MAX:    rd_mux = lat_max;
      REG_LAT_NSEC:   rd_mux = lat_nsec;
      REG_FRAME_SIZE: rd_mux = frame_size;
      REG_FRAME_BUF:  rd_mux = frame_buf_word;
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_ready_q  <= 1'b0;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      snap_pkts   <= '0;
      snap_octets <= '0;
      snap_idle   <= '0;
      snap_ts     <= '0;
    end else begin
      ar_ready_q <= !ar_ready_q && !r_valid_q && S_AXI_ARVALID && ar_in_win;
      if (ar_hs) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_mux;
        case (ar_off)
          REG_PKTS_HI:   snap_pkts   <= pkts[31:0];
          REG_OCTETS_HI: snap_octets <= octets[31:0];
          REG_IDLE_HI:   snap_idle   <= octets_idle[31:0];
          REG_TS_SEC_HI: snap_ts     <= ts_sec[31:0];
          default:       ;
        endcase
      end else if (S_AXI_RREADY) begin
        r_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gmii_traffic_analyzer.sv
// GMII rx analyzer: frame/octet/idle counters, 1588 one-way latency (1 cycle after frame end), frame capture.
// Never backpressures GMII; TA_FRAME_CAPTURE_EN builds the capture buffer, otherwise FRAME_BUF reads 0.
module gmii_traffic_analyzer #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] C_BASEADDR         = 32'h2000_0000,
  parameter int          FRAME_BUF_WORDS    = 512
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [7:0]                      gmii_d,
  input  logic                            gmii_en,
  input  logic                            gmii_er,
  input  logic [47:0]                     sec,
  input  logic [29:0]                     nsec,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  import gmii_ta_pkg::*;

  rx_state_t    state_q, state_d;
  logic         sfd_hit, frame_end, data_byte;
  logic [63:0]  pkts, octets, octets_idle;
  logic [111:0] stamp_sr;
  logic [31:0]  byte_cnt, frame_size;
  ts_t          rx_ts_q, tx_ts;
  logic [47:0]  ts_sec_q;
  logic [31:0]  ts_nsec_q;
  logic         lat_pend;
  logic [31:0]  lat_new, lat_nsec, lat_min, lat_max;
  logic [31:0]  frame_buf_word;
  logic         ctrl_clear, frame_size_rd, frame_buf_rd;
  logic         unused_rx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    sfd_hit   = 1'b0;
    frame_end = 1'b0;
    data_byte = 1'b0;
    case (state_q)
      RX_IDLE: if (gmii_en) state_d = RX_PREAMBLE;
      RX_PREAMBLE: begin
        if (!gmii_en) begin
          state_d = RX_IDLE;
        end else if (gmii_d == GMII_SFD) begin
          state_d = RX_DATA;
          sfd_hit = 1'b1;
        end
      end
      RX_DATA: begin
        if (!gmii_en) begin
          state_d   = RX_IDLE;
          frame_end = 1'b1;
        end else begin
          data_byte = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkts        <= '0;
      octets      <= '0;
      octets_idle <= '0;
    end else if (ctrl_clear) begin
      pkts        <= '0;
      octets      <= '0;
      octets_idle <= '0;
    end else begin
      if (!gmii_en)  octets_idle <= octets_idle + 64'd1;
      if (data_byte) octets      <= octets + 64'd1;
      if (frame_end) pkts        <= pkts + 64'd1;
    end
  end

  // The last 14 data bytes are always in stamp_sr: 6 sec, 4 nsec, then the FCS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stamp_sr   <= '0;
      byte_cnt   <= '0;
      frame_size <= '0;
      rx_ts_q    <= '0;
      ts_sec_q   <= '0;
      ts_nsec_q  <= '0;
      lat_pend   <= 1'b0;
    end else begin
      lat_pend <= 1'b0;
      if (sfd_hit) begin
        rx_ts_q.sec  <= sec;
        rx_ts_q.nsec <= {2'b00, nsec};
        byte_cnt     <= '0;
      end
      if (data_byte) begin
        stamp_sr <= {stamp_sr[103:0], gmii_d};
        byte_cnt <= byte_cnt + 32'd1;
      end
      if (frame_end) begin
        frame_size <= byte_cnt;
        ts_sec_q   <= rx_ts_q.sec;
        ts_nsec_q  <= rx_ts_q.nsec;
        lat_pend   <= (byte_cnt >= STAMP_WIN_BYTES);
      end
    end
  end

  assign tx_ts     = stamp_sr[111:32];
  assign lat_new   = calc_latency(tx_ts, rx_ts_q);
  assign unused_rx = ^{gmii_er, stamp_sr[31:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_nsec <= '0;
      lat_min  <= LAT_SAT;
      lat_max  <= '0;
    end else if (ctrl_clear) begin
      lat_nsec <= '0;
      lat_min  <= LAT_SAT;
      lat_max  <= '0;
    end else if (lat_pend) begin
      lat_nsec <= lat_new;
      if (lat_new < lat_min) lat_min <= lat_new;
      if (lat_new > lat_max) lat_max <= lat_new;
    end
  end

`ifdef TA_FRAME_CAPTURE_EN
  localparam int BUF_AW = $clog2(FRAME_BUF_WORDS);

  logic [31:0]       frame_buf [FRAME_BUF_WORDS];
  logic [BUF_AW-1:0] rd_ptr;
  logic              buf_wr;
  logic [1:0]        wr_lane;

  assign buf_wr  = data_byte && (byte_cnt < 32'(FRAME_BUF_WORDS * 4));
  assign wr_lane = 2'd3 - byte_cnt[1:0];

  // First byte of each word lands in [31:24].
  always_ff @(posedge clk) begin
    if (buf_wr) frame_buf[byte_cnt[BUF_AW+1:2]][{wr_lane, 3'b000} +: 8] <= gmii_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         rd_ptr <= '0;
    else if (frame_end || frame_size_rd) rd_ptr <= '0;
    else if (frame_buf_rd)               rd_ptr <= rd_ptr + 1'b1;
  end

  assign frame_buf_word = frame_buf[rd_ptr];
`else
  logic unused_buf;
  assign unused_buf     = frame_size_rd ^ frame_buf_rd;
  assign frame_buf_word = '0;
`endif

  gmii_ta_regs #(
    .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .C_BASEADDR         (C_BASEADDR)
  ) u_regs (
    .clk            (clk),
    .resetn         (resetn),
    .S_AXI_AWADDR   (S_AXI_AWADDR),
    .S_AXI_AWVALID  (S_AXI_AWVALID),
    .S_AXI_AWREADY  (S_AXI_AWREADY),
    .S_AXI_WDATA    (S_AXI_WDATA),
    .S_AXI_WSTRB    (S_AXI_WSTRB),
    .S_AXI_WVALID   (S_AXI_WVALID),
    .S_AXI_WREADY   (S_AXI_WREADY),
    .S_AXI_BRESP    (S_AXI_BRESP),
    .S_AXI_BVALID   (S_AXI_BVALID),
    .S_AXI_BREADY   (S_AXI_BREADY),
    .S_AXI_ARADDR   (S_AXI_ARADDR),
    .S_AXI_ARVALID  (S_AXI_ARVALID),
    .S_AXI_ARREADY  (S_AXI_ARREADY),
    .S_AXI_RDATA    (S_AXI_RDATA),
    .S_AXI_RRESP    (S_AXI_RRESP),
    .S_AXI_RVALID   (S_AXI_RVALID),
    .S_AXI_RREADY   (S_AXI_RREADY),
    .pkts           (pkts),
    .octets         (octets),
    .octets_idle    (octets_idle),
    .ts_sec         (ts_sec_q),
    .ts_nsec        (ts_nsec_q),
    .lat_min        (lat_min),
    .lat_max        (lat_max),
    .lat_nsec       (lat_nsec),
    .frame_size     (frame_size),
    .frame_buf_word (frame_buf_word),
    .ctrl_clear     (ctrl_clear),
    .frame_size_rd  (frame_size_rd),
    .frame_buf_rd   (frame_buf_rd)
  );

endmodule

// File: tb/tb_gmii_traffic_analyzer.sv
// Directed bench for gmii_traffic_analyzer: GMII frames in, AXI4-Lite register reads checked.
// Expected FRAME_BUF contents depend on TA_FRAME_CAPTURE_EN.
module tb_gmii_traffic_analyzer;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  gmii_d;
  logic        gmii_en, gmii_er;
  logic [47:0] sec;
  logic [29:0] nsec;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0]  fb [64];
  logic [63:0] v64, idle_before;
  logic [31:0] v32, lo_a, lo_b, exp_w;

  gmii_traffic_analyzer dut (
    .clk(clk), .resetn(resetn),
    .gmii_d(gmii_d), .gmii_en(gmii_en), .gmii_er(gmii_er), .sec(sec), .nsec(nsec),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    gmii_en = 1'b0;
    gmii_d  = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    gmii_en = 1'b1;
    gmii_d  = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input int len);
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 0; i < len; i++) send_byte(fb[i]);
    gmii_en = 1'b0;
    gmii_d  = 8'h00;
  endtask

  task automatic build_frame(input logic [47:0] ts, input logic [31:0] tn);
    for (int k = 0; k < 64; k++) fb[k] = 8'(k);
    for (int k = 0; k < 6; k++)  fb[50+k] = ts[47-8*k -: 8];
    for (int k = 0; k < 4; k++)  fb[56+k] = tn[31-8*k -: 8];
  endtask

  task automatic axi_read(input logic [15:0] off, output logic [31:0] d);
    int  n;
    logic ok;
    araddr  = BASE | {16'h0, off};
    arvalid = 1'b1;
    rready  = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    ok = (rvalid === 1'b1);
    d  = rdata;
    @(negedge clk);
    rready = 1'b0;
    check("rd_handshake", {63'd0, ok}, 64'd1);
  endtask

  task automatic read64(input logic [15:0] hi_off, output logic [63:0] d);
    logic [31:0] hi, lo;
    axi_read(hi_off, hi);
    axi_read(hi_off + 16'h4, lo);
    d = {hi, lo};
  endtask

  task automatic axi_write(input logic [15:0] off, input logic [31:0] v);
    int  n;
    logic ok;
    awaddr  = BASE | {16'h0, off};
    wdata   = v;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    ok = (bvalid === 1'b1) && (bresp === 2'b00);
    @(negedge clk);
    bready = 1'b0;
    check("wr_handshake", {63'd0, ok}, 64'd1);
  endtask

  initial begin
    resetn = 1'b0; gmii_d = 8'h00; gmii_en = 1'b0; gmii_er = 1'b0;
    sec = '0; nsec = '0;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of the AXI outputs.
    check("rst_ready", {60'd0, awready, wready, arready, 1'b0}, 64'd0);
    check("rst_valid", {62'd0, bvalid, rvalid}, 64'd0);
    check("rst_rdata_resp", {28'd0, rresp, bresp, rdata}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    read64(16'h0000, v64);  check("rst_pkts", v64, 64'd0);
    axi_read(16'h0024, v32); check("rst_lat_min", {32'd0, v32}, 64'hFFFF_FFFF);
    axi_read(16'h0028, v32); check("rst_lat_max", {32'd0, v32}, 64'd0);
    axi_read(16'h0040, v32); check("unmapped", {32'd0, v32}, 64'd0);

    // Long idle, then ten 64-byte frames separated by 12 idle cycles.
    idle_cycles(33600);
    for (int f = 0; f < 10; f++) begin
      build_frame(48'h0, 32'h0);
      send_frame(64);
      idle_cycles(12);
    end
    read64(16'h0000, v64); check("pkts_10", v64, 64'd10);
    read64(16'h0008, v64); check("octets_640", v64, 64'd640);
    read64(16'h0010, v64); check("idle_ge_33720", {63'd0, (v64 >= 64'd33720)}, 64'd1);

    // Lo half comes from the hi-read snapshot, not the still-running counter.
    axi_read(16'h0010, v32);
    idle_cycles(20);
    axi_read(16'h0014, lo_a);
    axi_read(16'h0014, lo_b);
    check("idle_snapshot", {32'd0, lo_b}, {32'd0, lo_a});

    // Clear while gmii_en is held in a never-ending preamble so idle stays frozen.
    send_byte(8'h55);
    gmii_en = 1'b1;
    gmii_d  = 8'h55;
    axi_write(16'h0038, 32'h1);
    read64(16'h0000, v64);   check("clr_pkts", v64, 64'd0);
    read64(16'h0008, v64);   check("clr_octets", v64, 64'd0);
    read64(16'h0010, v64);   check("clr_idle", v64, 64'd0);
    axi_read(16'h0024, v32); check("clr_lat_min", {32'd0, v32}, 64'hFFFF_FFFF);
    axi_read(16'h0028, v32); check("clr_lat_max", {32'd0, v32}, 64'd0);
    axi_read(16'h0038, v32); check("control_rd", {32'd0, v32}, 64'd0);
    idle_cycles(4);

    // Same-second latency: 1500 - 1000 = 500.
    build_frame(48'd5, 32'd1000);
    sec = 48'd5; nsec = 30'd1500;
    send_frame(64);
    idle_cycles(4);
    axi_read(16'h002C, v32); check("lat_500", {32'd0, v32}, 64'd500);
    axi_read(16'h0024, v32); check("min_500", {32'd0, v32}, 64'd500);
    axi_read(16'h0028, v32); check("max_500", {32'd0, v32}, 64'd500);
    axi_read(16'h0020, v32); check("ts_nsec", {32'd0, v32}, 64'd1500);
    read64(16'h0018, v64);   check("ts_sec", v64, 64'd5);

    // Second rollover: 100 + 1e9 - 999999900 = 200.
    build_frame(48'd4, 32'd999_999_900);
    sec = 48'd5; nsec = 30'd100;
    send_frame(64);
    idle_cycles(4);
    axi_read(16'h002C, v32); check("lat_200", {32'd0, v32}, 64'd200);
    axi_read(16'h0024, v32); check("min_200", {32'd0, v32}, 64'd200);
    axi_read(16'h0028, v32); check("max_keep_500", {32'd0, v32}, 64'd500);

    // 10-byte frame is too short for a stamp: latency untouched.
    build_frame(48'd0, 32'd0);
    sec = 48'd9; nsec = 30'd0;
    send_frame(10);
    idle_cycles(4);
    axi_read(16'h0030, v32); check("short_size", {32'd0, v32}, 64'd10);
    axi_read(16'h002C, v32); check("short_lat", {32'd0, v32}, 64'd200);
    read64(16'h0000, v64);   check("pkts_3", v64, 64'd3);

    // Capture frame starting DE AD BE EF, latency 1500 - 1450 = 50.
    build_frame(48'd5, 32'd1450);
    fb[0] = 8'hDE; fb[1] = 8'hAD; fb[2] = 8'hBE; fb[3] = 8'hEF;
    sec = 48'd5; nsec = 30'd1500;
    send_frame(64);
    idle_cycles(4);
    axi_read(16'h002C, v32); check("lat_50", {32'd0, v32}, 64'd50);
    axi_read(16'h0024, v32); check("min_50", {32'd0, v32}, 64'd50);
    axi_read(16'h0030, v32); check("frame_size_64", {32'd0, v32}, 64'd64);
    for (int w = 0; w < 16; w++) begin
`ifdef TA_FRAME_CAPTURE_EN
      exp_w = {fb[4*w], fb[4*w+1], fb[4*w+2], fb[4*w+3]};
`else
      exp_w = 32'h0;
`endif
      axi_read(16'h0034, v32);
      check($sformatf("frame_buf_%0d", w), {32'd0, v32}, {32'd0, exp_w});
    end

    // Fragment: three preamble bytes then gmii_en drops.
    read64(16'h0010, idle_before);
    send_byte(8'h55); send_byte(8'h55); send_byte(8'h55);
    idle_cycles(5);
    read64(16'h0000, v64); check("frag_pkts", v64, 64'd4);
    read64(16'h0008, v64); check("frag_octets", v64, 64'd202);
    read64(16'h0010, v64); check("frag_idle_grows", {63'd0, (v64 > idle_before)}, 64'd1);

    // A normal frame after the fragment still counts.
    build_frame(48'd0, 32'd0);
    send_frame(64);
    idle_cycles(4);
    read64(16'h0000, v64); check("post_frag_pkts", v64, 64'd5);
    read64(16'h0008, v64); check("post_frag_octets", v64, 64'd266);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
